// File: rtl/matmul_apb_master.sv
// -----------------------------------------------------------------------------
// matmul_apb_master
//
// APB4 requester for the matmul slave port. It accepts one command on a
// valid/ready interface, performs exactly one APB transfer, and returns the
// result on a valid/ready response interface. Only one transfer is ever in
// flight. A slave that holds pready low for TIMEOUT ACCESS cycles is abandoned
// and the response reports an error flagged as a timeout.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_strb_i    command payload
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_rdata_o                read data (0 for writes and timeouts)
//   rsp_err_o, rsp_tmo_o       slave error or timeout / timeout only
//   psel_o, penable_o,
//   pwrite_o, pstrb_o,
//   pwdata_o, paddr_o          APB request signals
//   pready_i, pslverr_i,
//   prdata_i                   APB completion signals
//   busy_o                     high whenever a transfer is in progress
//
// Every output is taken directly from a flop.
// -----------------------------------------------------------------------------
module matmul_apb_master #(
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]   cmd_wdata_i,
    input  logic [BUS_WIDTH/8-1:0] cmd_strb_i,

    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [BUS_WIDTH-1:0]   rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   rsp_tmo_o,

    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [BUS_WIDTH/8-1:0] pstrb_o,
    output logic [BUS_WIDTH-1:0]   pwdata_o,
    output logic [ADDR_WIDTH-1:0]  paddr_o,
    input  logic                   pready_i,
    input  logic                   pslverr_i,
    input  logic [BUS_WIDTH-1:0]   prdata_i,

    output logic                   busy_o
);

    localparam int STRB_W = BUS_WIDTH / 8;

    // The counter holds the number of ACCESS cycles already spent waiting;
    // the abort fires on the cycle that would make it reach TIMEOUT, so it
    // never has to represent TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q,      busy_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [BUS_WIDTH-1:0]  pwdata_q,    pwdata_d;
    logic [STRB_W-1:0]     pstrb_q,     pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_tmo_q,   rsp_tmo_d;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;

        unique case (state_q)
            S_IDLE: begin
                // cmd_ready_q is always 1 here, so valid alone is the handshake.
                if (cmd_valid_i) begin
                    state_d     = S_SETUP;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    pwrite_d    = cmd_write_i;
                    paddr_d     = cmd_addr_i;
                    // Reads present an all-zero data/strobe pattern on the bus.
                    pwdata_d    = cmd_write_i ? cmd_wdata_i : '0;
                    pstrb_d     = cmd_write_i ? cmd_strb_i  : '0;
                end
            end

            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end

            S_ACCESS: begin
                // pready is checked before the terminal count, so a slave that
                // answers on the last allowed cycle still completes normally.
                if (pready_i) begin
                    state_d     = S_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                    rsp_err_d   = pslverr_i;
                    rsp_tmo_d   = 1'b0;
                end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
                    state_d     = S_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    rsp_tmo_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // All state here is small control and datapath flops, so everything is
    // reset; an abort by reset leaves the bus idle with no response pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign busy_o      = busy_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;

endmodule
